// File: rtl/sum_latch_ctrl.sv
// Operand-capture and UART-handoff sequencer: loads A then B from a shared
// nibble bus, strobes the matching latch, registers A+B and hands it to the TX.
module sum_latch_ctrl #(
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              tx_busy,
    output logic [DATA_W-1:0] latch_data,
    output logic              save_a,
    output logic              save_b,
    output logic [DATA_W:0]   sum_out,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        SUM     = 3'd3,
        TX_REQ  = 3'd4,
        TX_WAIT = 3'd5
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [15:0]         timer_q, timer_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   latch_data_q, latch_data_d;
    logic                save_a_q, save_a_d;
    logic                save_b_q, save_b_d;
    logic [DATA_W:0]     sum_q, sum_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            latch_data_q <= '0;
            save_a_q     <= 1'b0;
            save_b_q     <= 1'b0;
            sum_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            latch_data_q <= latch_data_d;
            save_a_q     <= save_a_d;
            save_b_q     <= save_b_d;
            sum_q        <= sum_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // TX handshake: tx_start is a request held while in TX_REQ; the first
    // sampled tx_busy=1 is the acknowledge, and tx_busy=0 afterwards means
    // the frame has gone out.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        latch_data_d = latch_data_q;
        save_a_d     = 1'b0;
        save_b_d     = 1'b0;
        sum_d        = sum_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        done_d       = 1'b0;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_A;
                    err_d   = 1'b0;
                    timer_d = '0;
                end
            end
            LOAD_A: begin
                if (data_valid) begin
                    op_a_d       = data_in;
                    latch_data_d = data_in;
                    save_a_d     = 1'b1;
                    timer_d      = '0;
                    state_d      = LOAD_B;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            LOAD_B: begin
                if (data_valid) begin
                    op_b_d       = data_in;
                    latch_data_d = data_in;
                    save_b_d     = 1'b1;
                    timer_d      = '0;
                    state_d      = SUM;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            SUM: begin
                sum_d      = {1'b0, op_a_q} + {1'b0, op_b_q};
                tx_data_d  = 8'(sum_d);
                timer_d    = '0;
                tx_start_d = 1'b1;
                state_d    = TX_REQ;
            end
            TX_REQ: begin
                if (tx_busy) begin
                    state_d = TX_WAIT;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d    = timer_q + 16'd1;
                    tx_start_d = 1'b1;
                end
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign latch_data = latch_data_q;
    assign save_a     = save_a_q;
    assign save_b     = save_b_q;
    assign sum_out    = sum_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule
